// File: rtl/sipo_deser_ctrl.sv
// sipo_deser_ctrl: serial-in/parallel-out controller with frame resync and a double-buffered word output
// The shift register doubles as the second buffer: a completed word waits there (STALL) until the output slot frees.
module sipo_deser_ctrl #(
    parameter int WIDTH = 4,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in_i,
    input  logic             bit_valid_i,
    output logic             bit_ready_o,
    input  logic             frame_start_i,
    output logic [WIDTH-1:0] word_out_o,
    output logic             word_valid_o,
    input  logic             word_ready_i,
    output logic [CW-1:0]    bit_count_o,
    output logic             frame_err_o
);
    typedef enum logic {COLLECT, STALL} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d, word_q, word_d, shifted;
    logic [CW-1:0] cnt_q, cnt_d, cnt_base;
    logic valid_q, valid_d, ferr_q, ferr_d, bit_acc, word_acc, complete;
    assign bit_ready_o  = (state_q == COLLECT) & ~rst;
    assign bit_acc      = bit_valid_i & bit_ready_o;
    assign word_acc     = valid_q & word_ready_i;
    // frame_start makes the accepted bit position 0 regardless of the count so far
    assign cnt_base     = frame_start_i ? '0 : cnt_q;
    assign complete     = bit_acc & (cnt_base == CW'(WIDTH - 1));
    assign shifted      = MSB_FIRST ? {sr_q[WIDTH-2:0], bit_in_i} : {bit_in_i, sr_q[WIDTH-1:1]};
    assign word_out_o   = word_q;
    assign word_valid_o = valid_q;
    assign bit_count_o  = cnt_q;
    assign frame_err_o  = ferr_q;
    always_comb begin
        state_d = state_q;
        sr_d    = bit_acc ? shifted : sr_q;
        cnt_d   = bit_acc ? (complete ? '0 : cnt_base + CW'(1)) : cnt_q;
        word_d  = word_q;
        valid_d = valid_q & ~word_acc;
        ferr_d  = bit_acc & frame_start_i & (cnt_q != '0);
        if (state_q == STALL) begin
            if (word_acc) begin
                word_d  = sr_q;
                valid_d = 1'b1;
                state_d = COLLECT;
            end
        end else if (complete) begin
            if (!valid_q || word_acc) begin
                word_d  = shifted;
                valid_d = 1'b1;
            end else begin
                state_d = STALL;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            sr_q    <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end
endmodule

// File: tb/tb_sipo_deser_ctrl.sv
// tb_sipo_deser_ctrl: MSB-first and LSB-first instances driven in lockstep against a bit-list reference model
module tb_sipo_deser_ctrl;
    localparam int W = 4;
    logic clk = 1'b0, rst, bit_in, bit_valid, frame_start, word_ready;
    logic br[2], wv[2], fo[2];
    logic [W-1:0] wo[2];
    logic [1:0] bc[2];
    int n_chk = 0, n_fail = 0;
    int pn[2];
    bit pb[2][W];
    bit [W-1:0] ow[2], pw[2];
    bit ov[2], pd[2], fe[2];

    always #5 clk = ~clk;

    sipo_deser_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .bit_in_i(bit_in), .bit_valid_i(bit_valid), .bit_ready_o(br[0]),
        .frame_start_i(frame_start), .word_out_o(wo[0]), .word_valid_o(wv[0]),
        .word_ready_i(word_ready), .bit_count_o(bc[0]), .frame_err_o(fo[0]));
    sipo_deser_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .bit_in_i(bit_in), .bit_valid_i(bit_valid), .bit_ready_o(br[1]),
        .frame_start_i(frame_start), .word_out_o(wo[1]), .word_valid_o(wv[1]),
        .word_ready_i(word_ready), .bit_count_o(bc[1]), .frame_err_o(fo[1]));

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the partial word is a list of received bits; a full word that finds the slot busy waits in pw.
    task automatic model_step(int d);
        bit bacc, wacc;
        int w;
        if (rst) begin
            pn[d] = 0; ow[d] = '0; ov[d] = 0; pd[d] = 0; fe[d] = 0;
        end else begin
            bacc  = bit_valid & !pd[d];
            wacc  = ov[d] & word_ready;
            fe[d] = bacc & frame_start & (pn[d] != 0);
            if (wacc) ov[d] = 0;
            if (pd[d] && wacc) begin
                ow[d] = pw[d]; ov[d] = 1; pd[d] = 0;
            end
            if (bacc) begin
                if (frame_start) pn[d] = 0;
                pb[d][pn[d]] = bit_in;
                pn[d]++;
                if (pn[d] == W) begin
                    w = 0;
                    for (int i = 0; i < W; i++)
                        if (pb[d][i]) w += 1 << ((d == 0) ? (W - 1 - i) : i);
                    pn[d] = 0;
                    if (!ov[d]) begin
                        ow[d] = W'(w); ov[d] = 1;
                    end else begin
                        pw[d] = W'(w); pd[d] = 1;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("bit_ready[%0d]", d), int'(br[d]), int'(!pd[d] && !rst));
            chk($sformatf("word_valid[%0d]", d), int'(wv[d]), int'(ov[d]));
            chk($sformatf("word_out[%0d]", d), int'(wo[d]), int'(ow[d]));
            chk($sformatf("bit_count[%0d]", d), int'(bc[d]), pn[d]);
            chk($sformatf("frame_err[%0d]", d), int'(fo[d]), int'(fe[d]));
        end
    endtask

    task automatic drive(bit r, bit bv, bit bi, bit fs, bit wr);
        rst = r; bit_valid = bv; bit_in = bi; frame_start = fs; word_ready = wr;
        model_step(0);
        model_step(1);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic send4(bit [W-1:0] b, bit wr);
        for (int i = W - 1; i >= 0; i--) drive(0, 1, b[i], 0, wr);
    endtask

    initial begin
        rst = 1; bit_valid = 0; bit_in = 0; frame_start = 0; word_ready = 1;
        @(negedge clk);
        drive(1, 0, 0, 0, 1);
        drive(1, 1, 1, 0, 1);
        chk("rst_ready", int'(br[0]), 0);
        chk("rst_valid", int'(wv[0]), 0);
        drive(0, 0, 0, 0, 1);
        // bits 1,0,1,1
        send4(4'b1011, 1);
        chk("t1_msb_word", int'(wo[0]), 4'b1011);
        chk("t1_lsb_word", int'(wo[1]), 4'b1101);
        chk("t1_valid", int'(wv[0]), 1);
        drive(0, 0, 0, 0, 1);
        chk("t1_valid_1cyc", int'(wv[0]), 0);
        // backpressure: second word stalls in the shift register
        send4(4'b1011, 0);
        send4(4'b0110, 0);
        chk("t3_hold", int'(wo[0]), 4'b1011);
        chk("t3_stall_ready", int'(br[0]), 0);
        chk("t3_stall_count", int'(bc[0]), 0);
        drive(0, 0, 0, 0, 1);
        chk("t3_second", int'(wo[0]), 4'b0110);
        chk("t3_ready_back", int'(br[0]), 1);
        chk("t3_valid_kept", int'(wv[0]), 1);
        drive(0, 0, 0, 0, 1);
        // resync discards the partial 1,1
        drive(0, 1, 1, 0, 1);
        drive(0, 1, 1, 0, 1);
        chk("t4_count2", int'(bc[0]), 2);
        drive(0, 1, 0, 1, 1);
        chk("t4_ferr", int'(fo[0]), 1);
        chk("t4_count1", int'(bc[0]), 1);
        drive(0, 1, 1, 0, 1);
        chk("t4_ferr_pulse", int'(fo[0]), 0);
        drive(0, 1, 0, 0, 1);
        drive(0, 1, 1, 0, 1);
        chk("t4_msb_word", int'(wo[0]), 4'b0101);
        chk("t4_lsb_word", int'(wo[1]), 4'b1010);
        drive(0, 0, 0, 0, 1);
        // sparse bits, one every third cycle
        for (int i = W - 1; i >= 0; i--) begin
            drive(0, 1, (4'b1011 >> i) & 1'b1, 0, 1);
            if (i != 0) begin
                drive(0, 0, 0, 0, 1);
                drive(0, 0, 1, 0, 1);
            end
        end
        chk("t5_word", int'(wo[0]), 4'b1011);
        chk("t5_valid", int'(wv[0]), 1);
        // reset mid-word
        drive(0, 1, 1, 0, 1);
        drive(0, 1, 1, 0, 1);
        drive(1, 1, 1, 0, 1);
        chk("t6_rst_valid", int'(wv[0]), 0);
        chk("t6_rst_ready", int'(br[0]), 0);
        chk("t6_rst_count", int'(bc[0]), 0);
        send4(4'b0011, 1);
        chk("t6_msb_word", int'(wo[0]), 4'b0011);
        chk("t6_lsb_word", int'(wo[1]), 4'b1100);
        for (int c = 0; c < 3000; c++)
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
